// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } serial_adder_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial adder's datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum_c,
  output logic carry_out_c
);

  assign sum_c       = a ^ b ^ carry_in;
  assign carry_out_c = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one result bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             serial_adder_clk,
  input  logic             serial_adder_rst,
  input  logic             serial_adder_in_valid,
  output logic             serial_adder_in_ready,
  input  logic [WIDTH-1:0] serial_adder_a,
  input  logic [WIDTH-1:0] serial_adder_b,
  input  logic             serial_adder_carry_in,
  output logic             serial_adder_out_valid,
  input  logic             serial_adder_out_ready,
  output logic [WIDTH-1:0] serial_adder_sum,
  output logic             serial_adder_carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             serial_adder_overflow
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  serial_adder_state_t state_q, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_sum_c, fa_carry_out_c;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  full_adder u_full_adder (
    .a           (a_sr[0]),
    .b           (b_sr[0]),
    .carry_in    (carry_q),
    .sum_c       (fa_sum_c),
    .carry_out_c (fa_carry_out_c)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (serial_adder_in_valid) state_nxt = ADD;
      ADD:     if (last_c) state_nxt = DONE;
      DONE:    if (serial_adder_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state
  always_ff @(posedge serial_adder_clk or posedge serial_adder_rst) begin
    if (serial_adder_rst) begin
      state_q                <= IDLE;
      serial_adder_in_ready  <= 1'b1;
      serial_adder_out_valid <= 1'b0;
    end else begin
      state_q                <= state_nxt;
      serial_adder_in_ready  <= (state_nxt == IDLE);
      serial_adder_out_valid <= (state_nxt == DONE);
    end
  end

  // Operand/result shift registers, carry and bit counter
  always_ff @(posedge serial_adder_clk or posedge serial_adder_rst) begin
    if (serial_adder_rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (serial_adder_in_valid) begin
            a_sr    <= serial_adder_a;
            b_sr    <= serial_adder_b;
            sum_sr  <= '0;
            carry_q <= serial_adder_carry_in;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr  <= {fa_sum_c, sum_sr[WIDTH-1:1]};
          carry_q <= fa_carry_out_c;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign serial_adder_sum       = sum_sr;
  assign serial_adder_carry_out = carry_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge serial_adder_clk or posedge serial_adder_rst) begin
    if (serial_adder_rst) begin
      serial_adder_overflow <= 1'b0;
    end else if (state_q == ADD && last_c) begin
      serial_adder_overflow <= carry_q ^ fa_carry_out_c;
    end
  end
`else
  // Overflow tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs. an arithmetic model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .serial_adder_clk       (clk),
    .serial_adder_rst       (rst),
    .serial_adder_in_valid  (in_valid),
    .serial_adder_in_ready  (in_ready),
    .serial_adder_a         (a),
    .serial_adder_b         (b),
    .serial_adder_carry_in  (cin),
    .serial_adder_out_valid (out_valid),
    .serial_adder_out_ready (out_ready),
    .serial_adder_sum       (sum),
    .serial_adder_carry_out (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .serial_adder_overflow  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit addition; overflow from the two's-complement sign rule
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
    logic [WIDTH:0] r;
    r = ref_add(x, y, c);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // One full transaction; starts and ends at a falling edge with the DUT idle
  task automatic xact(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                      input int hold, input logic stray, input logic early_ready);
    logic [WIDTH:0] exp;
    logic [WIDTH-1:0] held_sum;
    logic held_cout;
    int edges;
    exp = ref_add(xa, xb, xc);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk); @(negedge clk);
    if (stray) begin
      a = 8'h11; b = 8'h22; cin = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = early_ready;
    edges = 0;
    while (!out_valid && edges < int'(WIDTH) + 4) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(edges), 32'(WIDTH));
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    chk("carry_out", 32'(cout), 32'(exp[WIDTH]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("overflow", 32'(ovf), 32'(ref_ovf(xa, xb, xc)));
`endif
    held_sum = exp[WIDTH-1:0];
    held_cout = exp[WIDTH];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(held_sum));
      chk("hold_cout", 32'(cout), 32'(held_cout));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("ret_in_ready", 32'(in_ready), 32'd1);
    chk("ret_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Wrap-around into carry_out
    xact(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    // carry_in used, long stall in DONE
    xact(8'h5A, 8'h33, 1'b1, 5, 1'b0, 1'b0);
    // in_valid during ADD must not be taken; out_ready before DONE ignored
    xact(8'h0F, 8'h01, 1'b0, 1, 1'b1, 1'b1);

    // Abort mid-ADD with an asynchronous reset pulse
    in_valid = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    xact(8'h02, 8'h03, 1'b0, 0, 1'b0, 1'b0);

    // Signed-overflow boundary cases
    xact(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    xact(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    xact(8'h80, 8'h80, 1'b1, 2, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      xact(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
